// File: rtl/fp32_mul_result_buffer.sv
// rtl/fp32_mul_result_buffer.sv - FWFT result FIFO for an FP32 multiplier
// with sticky exception flags and saturating exception/overflow counters.
module fp32_mul_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_res,
  input  logic [2:0]                 in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_res,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     level,
  output logic [2:0]                 sticky_flags,
  input  logic                       sticky_clr,
  output logic [CNT_W-1:0]           exc_cnt,
  output logic [CNT_W-1:0]           ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    FULL    = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]    mem_res_q   [DEPTH];
  logic [2:0]     mem_flags_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [2:0]     sticky_q, sticky_d;
  logic [CNT_W-1:0] exc_q, exc_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  logic push, pop, exc_hit, ovf_hit;

  assign in_ready  = (level_q != FULL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign exc_hit   = push && in_flags[2];
  assign ovf_hit   = push && (in_flags[1] || in_flags[0]);

  assign out_res      = mem_res_q[rd_ptr_q];
  assign out_flags    = mem_flags_q[rd_ptr_q];
  assign level        = level_q;
  assign sticky_flags = sticky_q;
  assign exc_cnt      = exc_q;
  assign ovf_cnt      = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sticky_d = sticky_q;
    exc_d    = exc_q;
    ovf_d    = ovf_q;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;

    // A push in the clear cycle still records its flags (set beats clear).
    if (sticky_clr) begin
      sticky_d = push ? in_flags : 3'b000;
      exc_d    = exc_hit ? CNT_W'(1) : '0;
      ovf_d    = ovf_hit ? CNT_W'(1) : '0;
    end else begin
      if (push) sticky_d = sticky_q | in_flags;
      if (exc_hit && exc_q != CNT_MAX) exc_d = exc_q + 1'b1;
      if (ovf_hit && ovf_q != CNT_MAX) ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sticky_q <= '0;
      exc_q    <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
      exc_q    <= exc_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage is not reset; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res_q[wr_ptr_q]   <= in_res;
      mem_flags_q[wr_ptr_q] <= in_flags;
    end
  end

endmodule

// File: tb/tb_fp32_mul_result_buffer.sv
// tb/tb_fp32_mul_result_buffer.sv - self-checking bench for fp32_mul_result_buffer
// using a queue-based reference model with directed and random steps.
module tb_fp32_mul_result_buffer;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [2:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  out_flags;
  logic [2:0]  level;
  logic [2:0]  sticky_flags;
  logic        sticky_clr;
  logic [7:0]  exc_cnt;
  logic [7:0]  ovf_cnt;

  int total = 0;
  int bad   = 0;

  logic [34:0] mq[$];
  logic [2:0]  m_sticky;
  int          m_exc;
  int          m_ovf;

  fp32_mul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
    .level(level), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .exc_cnt(exc_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = 3'b000;
    m_exc = 0;
    m_ovf = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"}, 32'(level), 32'(mq.size()));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() > 0) begin
      check({tag, ".out_res"}, out_res, mq[0][34:3]);
      check({tag, ".out_flags"}, 32'(out_flags), 32'(mq[0][2:0]));
    end
    check({tag, ".sticky"}, 32'(sticky_flags), 32'(m_sticky));
    check({tag, ".exc_cnt"}, 32'(exc_cnt), 32'(m_exc));
    check({tag, ".ovf_cnt"}, 32'(ovf_cnt), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs at the falling edge, update the model at the
  // rising edge, then compare at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [31:0] r,
                      input logic [2:0] f, input logic rdy, input logic clr);
    bit do_push, do_pop, e_hit, o_hit;
    in_valid = v; in_res = r; in_flags = f; out_ready = rdy; sticky_clr = clr;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() > 0);
    e_hit   = do_push && f[2];
    o_hit   = do_push && (f[1] || f[0]);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({r, f});
    if (clr) begin
      m_sticky = do_push ? f : 3'b000;
      m_exc = e_hit ? 1 : 0;
      m_ovf = o_hit ? 1 : 0;
    end else begin
      if (do_push) m_sticky = m_sticky | f;
      if (e_hit && m_exc < CNT_MAX) m_exc++;
      if (o_hit && m_ovf < CNT_MAX) m_ovf++;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_res = '0; in_flags = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    step("idle", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);

    // Single entry
    step("single.push", 1'b1, 32'h4532_10E9, 3'b000, 1'b0, 1'b0);
    check("single.res_const", out_res, 32'h4532_10E9);
    step("single.pop", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("single.empty", 32'(out_valid), 32'd0);

    // Fill and backpressure
    step("fill0", 1'b1, 32'hC235_5062, 3'b000, 1'b0, 1'b0);
    step("fill1", 1'b1, 32'h441E_5375, 3'b000, 1'b0, 1'b0);
    step("fill2", 1'b1, 32'h4B80_0000, 3'b000, 1'b0, 1'b0);
    step("fill3", 1'b1, 32'h361F_FFE7, 3'b000, 1'b0, 1'b0);
    check("fill.level4", 32'(level), 32'd4);
    check("fill.not_ready", 32'(in_ready), 32'd0);
    step("fill.reject", 1'b1, 32'h0000_0000, 3'b111, 1'b0, 1'b0);
    check("fill.hold_res", out_res, 32'hC235_5062);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    check("drain.empty", 32'(level), 32'd0);

    // Simultaneous push and pop at level 2
    step("pp.pre0", 1'b1, 32'h1111_0001, 3'b000, 1'b0, 1'b0);
    step("pp.pre1", 1'b1, 32'h1111_0002, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("pp", 1'b1, $urandom, 3'b000, 1'b1, 1'b0);
      check("pp.level2", 32'(level), 32'd2);
    end
    for (int i = 0; i < 2; i++) step("pp.drain", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

    // Flags and clear
    step("flags.clr0", 1'b0, 32'h0, 3'b000, 1'b1, 1'b1);
    step("flags.a", 1'b1, 32'h0000_0000, 3'b100, 1'b1, 1'b0);
    step("flags.b", 1'b1, 32'hFF80_0000, 3'b010, 1'b1, 1'b0);
    step("flags.c", 1'b1, 32'h8000_0000, 3'b001, 1'b1, 1'b0);
    check("flags.sticky111", 32'(sticky_flags), 32'h7);
    check("flags.exc1", 32'(exc_cnt), 32'd1);
    check("flags.ovf2", 32'(ovf_cnt), 32'd2);
    step("flags.clr_push", 1'b1, 32'h3F80_0000, 3'b010, 1'b1, 1'b1);
    check("flags.sticky010", 32'(sticky_flags), 32'h2);
    check("flags.exc0", 32'(exc_cnt), 32'd0);
    check("flags.ovf1", 32'(ovf_cnt), 32'd1);

    // Saturation
    for (int i = 0; i < 300; i++) step("sat", 1'b1, $urandom, 3'b100, 1'b1, 1'b0);
    check("sat.exc255", 32'(exc_cnt), 32'd255);
    for (int i = 0; i < 3; i++) step("sat.hold", 1'b1, $urandom, 3'b100, 1'b1, 1'b0);
    check("sat.exc_hold", 32'(exc_cnt), 32'd255);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

    // Reset mid-operation, between clock edges
    step("rst.clr", 1'b0, 32'h0, 3'b000, 1'b1, 1'b1);
    while (mq.size() > 0) step("rst.drain", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("rst.fill", 1'b1, $urandom, 3'b111, 1'b0, 1'b0);
    check("rst.level3", 32'(level), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.async_level", 32'(level), 32'd0);
    check("rst.async_valid", 32'(out_valid), 32'd0);
    check("rst.async_ready", 32'(in_ready), 32'd1);
    check("rst.async_exc", 32'(exc_cnt), 32'd0);
    check("rst.async_ovf", 32'(ovf_cnt), 32'd0);
    check("rst.async_sticky", 32'(sticky_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst.after_idle", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    step("rst.after_push", 1'b1, 32'h4049_0FDB, 3'b001, 1'b0, 1'b0);
    step("rst.after_pop", 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
